// File: rtl/am_header_insert_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | am_header_insert_if                                                    |
// | AXI-Stream bundle used on both sides of am_header_insert.              |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
interface am_header_insert_if #(
   parameter int TDATA_WIDTH = 64,
   parameter int TDEST_WIDTH = 16,
   parameter int TID_WIDTH   = 16,
   parameter int TUSER_WIDTH = 16,
   parameter int TKEEP_WIDTH = TDATA_WIDTH / 8
);
   logic [TDATA_WIDTH-1:0] TDATA;
   logic                   TVALID;
   logic                   TREADY;
   logic [TDEST_WIDTH-1:0] TDEST;
   logic                   TLAST;
   logic [TKEEP_WIDTH-1:0] TKEEP;
   logic [TID_WIDTH-1:0]   TID;
   logic [TUSER_WIDTH-1:0] TUSER;

   modport master (
      output TDATA, TVALID, TDEST, TLAST, TKEEP, TID, TUSER,
      input  TREADY
   );

   modport slave (
      input  TDATA, TVALID, TDEST, TLAST, TKEEP, TID, TUSER,
      output TREADY
   );
endinterface
`default_nettype wire

// File: rtl/am_header_insert.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | am_header_insert                                                       |
// | Prepends a {TDEST, beat count, dest ID} header beat to each AXIS       |
// | packet. Optional length check/truncation: AM_HEADER_LEN_CHECK_EN.      |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module am_header_insert #(
   parameter int TDATA_WIDTH = 64,
   parameter int TDEST_WIDTH = 16,
   parameter int TID_WIDTH   = 16,
   parameter int TUSER_WIDTH = 16,
   parameter int TKEEP_WIDTH = TDATA_WIDTH / 8
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   am_header_insert_if.slave     in_axis,
   am_header_insert_if.master    out_axis,
   output logic                  err_len
);

   typedef enum logic [1:0] {
      S_HDR  = 2'd0,
      S_PAY  = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [TDATA_WIDTH-1:0] r_tdata;
   logic [TDATA_WIDTH-1:0] w_hdr;
   logic                   r_tvalid;
   logic                   r_tlast;
   logic [TKEEP_WIDTH-1:0] r_tkeep;
   logic [TDEST_WIDTH-1:0] r_tdest;
   logic                   w_slot_free;
   logic                   w_in_ready;
   logic                   w_load_hdr;
   logic                   w_load_pay;
   logic                   w_force_last;

   assign w_slot_free = ~r_tvalid | out_axis.TREADY;
   assign w_in_ready  = (r_state == S_PAY)  ? w_slot_free :
                        (r_state == S_DROP);

   always_comb begin
      w_hdr                      = '0;
      w_hdr[TID_WIDTH-1:0]       = in_axis.TID;
      w_hdr[16 +: TUSER_WIDTH]   = in_axis.TUSER;
      w_hdr[32 +: TDEST_WIDTH]   = in_axis.TDEST;
   end

`ifdef AM_HEADER_LEN_CHECK_EN
   logic [15:0]            r_beat_cnt;
   logic [TUSER_WIDTH-1:0] r_tuser;
   logic                   r_err;
   logic                   w_set_err;
   logic [16:0]            w_beat_num;
   logic [16:0]            w_tuser_ext;

   // 17-bit compare so a saturated counter cannot wrap into a false match
   assign w_beat_num  = {1'b0, r_beat_cnt} + 17'd1;
   assign w_tuser_ext = 17'(r_tuser);
`endif

   always_comb begin
      w_state_nxt  = r_state;
      w_load_hdr   = 1'b0;
      w_load_pay   = 1'b0;
      w_force_last = 1'b0;
`ifdef AM_HEADER_LEN_CHECK_EN
      w_set_err    = 1'b0;
`endif
      case (r_state)
         S_HDR: begin
            if (in_axis.TVALID && w_slot_free) begin
               w_load_hdr  = 1'b1;
               w_state_nxt = S_PAY;
            end
         end
         S_PAY: begin
            if (in_axis.TVALID && w_slot_free) begin
               w_load_pay = 1'b1;
`ifdef AM_HEADER_LEN_CHECK_EN
               if (in_axis.TLAST) begin
                  w_state_nxt = S_HDR;
                  w_set_err   = (w_beat_num != w_tuser_ext);
               end else if (w_beat_num >= w_tuser_ext) begin
                  w_force_last = 1'b1;
                  w_set_err    = 1'b1;
                  w_state_nxt  = S_DROP;
               end
`else
               if (in_axis.TLAST) begin
                  w_state_nxt = S_HDR;
               end
`endif
            end
         end
         S_DROP: begin
            if (in_axis.TVALID && in_axis.TLAST) begin
               w_state_nxt = S_HDR;
            end
         end
         default: w_state_nxt = S_HDR;
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_state  <= S_HDR;
         r_tdata  <= '0;
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
         r_tkeep  <= '0;
         r_tdest  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load_hdr) begin
            r_tdata  <= w_hdr;
            r_tkeep  <= '1;
            r_tlast  <= 1'b0;
            r_tdest  <= in_axis.TDEST;
            r_tvalid <= 1'b1;
         end else if (w_load_pay) begin
            r_tdata  <= in_axis.TDATA;
            r_tkeep  <= in_axis.TKEEP;
            r_tlast  <= in_axis.TLAST | w_force_last;
            r_tvalid <= 1'b1;
         end else if (out_axis.TREADY) begin
            r_tvalid <= 1'b0;
         end
      end
   end

`ifdef AM_HEADER_LEN_CHECK_EN
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_beat_cnt <= '0;
         r_tuser    <= '0;
         r_err      <= 1'b0;
      end else begin
         if (w_load_hdr) begin
            r_beat_cnt <= '0;
            r_tuser    <= in_axis.TUSER;
         end else if (w_load_pay && (r_beat_cnt != 16'hFFFF)) begin
            r_beat_cnt <= r_beat_cnt + 16'd1;
         end
         if (w_set_err) begin
            r_err <= 1'b1;
         end
      end
   end

   assign err_len = r_err;
`else
   assign err_len = 1'b0;
`endif

   assign in_axis.TREADY  = w_in_ready;
   assign out_axis.TDATA  = r_tdata;
   assign out_axis.TVALID = r_tvalid;
   assign out_axis.TLAST  = r_tlast;
   assign out_axis.TKEEP  = r_tkeep;
   assign out_axis.TDEST  = r_tdest;
   assign out_axis.TID    = '0;
   assign out_axis.TUSER  = '0;

endmodule
`default_nettype wire

// File: tb/tb_am_header_insert.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_am_header_insert                                                    |
// | Scoreboard bench for am_header_insert (either AM_HEADER_LEN_CHECK_EN). |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module tb_am_header_insert;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic [15:0] dest;
   } beat_t;

   logic  ap_clk = 1'b0;
   logic  ap_rst_n;
   logic  err_len;
   beat_t exp_q[$];
   beat_t prev;
   bit    stalled = 1'b0;
   bit    rand_rdy = 1'b0;
   bit    exp_err = 1'b0;
   int    checks = 0;
   int    errors = 0;
   int    out_beats = 0;

   always #5 ap_clk = ~ap_clk;

   am_header_insert_if #(.TDATA_WIDTH(64)) in_if ();
   am_header_insert_if #(.TDATA_WIDTH(64)) out_if ();

   am_header_insert #(.TDATA_WIDTH(64)) dut (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .in_axis  (in_if),
      .out_axis (out_if),
      .err_len  (err_len)
   );

   function automatic beat_t mk(input logic [63:0] d, input logic [7:0] k,
                                input logic l, input logic [15:0] t);
      beat_t r;
      r.data = d;
      r.keep = k;
      r.last = l;
      r.dest = t;
      return r;
   endfunction

   function automatic logic [63:0] hdr_of(input logic [15:0] tid, tuser, tdest);
      return {16'h0000, tdest, tuser, tid};
   endfunction

   always @(posedge ap_clk) begin
      #1;
      out_if.TREADY = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Scoreboard pop plus hold-while-stalled check, sampled mid-cycle
   always @(negedge ap_clk) begin
      beat_t cur;
      beat_t e;
      cur = mk(out_if.TDATA, out_if.TKEEP, out_if.TLAST, out_if.TDEST);
      if (!ap_rst_n) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            checks++;
            if (!out_if.TVALID || cur !== prev) begin
               errors++;
               $display("FAIL stall_hold: got valid=%b beat=%h want valid=1 beat=%h",
                        out_if.TVALID, cur, prev);
            end
         end
         if (out_if.TVALID && out_if.TREADY) begin
            out_beats++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_beat: got data=%h last=%b want none",
                        cur.data, cur.last);
            end else begin
               e = exp_q.pop_front();
               if (cur !== e) begin
                  errors++;
                  $display("FAIL beat: got data=%h keep=%h last=%b dest=%h want data=%h keep=%h last=%b dest=%h",
                           cur.data, cur.keep, cur.last, cur.dest,
                           e.data, e.keep, e.last, e.dest);
               end
            end
         end
         stalled = out_if.TVALID && !out_if.TREADY;
         prev    = cur;
      end
   end

   task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                             input logic [15:0] tid, tuser, tdest);
      bit hs = 1'b0;
      in_if.TDATA  = d;
      in_if.TKEEP  = k;
      in_if.TLAST  = l;
      in_if.TID    = tid;
      in_if.TUSER  = tuser;
      in_if.TDEST  = tdest;
      in_if.TVALID = 1'b1;
      for (int c = 0; c < 200; c++) begin
         @(negedge ap_clk);
         if (in_if.TREADY) begin
            hs = 1'b1;
            break;
         end
      end
      @(posedge ap_clk);
      #1;
      if (!hs) begin
         checks++;
         errors++;
         $display("FAIL in_handshake_timeout: got TREADY=0 want 1 within 200 cycles");
      end
   endtask

   task automatic send_pkt(input logic [15:0] tid, tuser, tdest,
                           input int n, input bit gaps);
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
      bit          dropping = 1'b0;
      exp_q.push_back(mk(hdr_of(tid, tuser, tdest), 8'hFF, 1'b0, tdest));
      for (int b = 1; b <= n; b++) begin
         d = {$urandom(), $urandom()};
         l = (b == n);
         k = l ? 8'($urandom_range(1, 255)) : 8'hFF;
`ifdef AM_HEADER_LEN_CHECK_EN
         if (!dropping) begin
            if (l) begin
               if (b != int'(tuser)) exp_err = 1'b1;
               exp_q.push_back(mk(d, k, 1'b1, tdest));
            end else if (b >= int'(tuser)) begin
               exp_err  = 1'b1;
               dropping = 1'b1;
               exp_q.push_back(mk(d, k, 1'b1, tdest));
            end else begin
               exp_q.push_back(mk(d, k, 1'b0, tdest));
            end
         end
`else
         exp_q.push_back(mk(d, k, l, tdest));
`endif
         if (gaps && $urandom_range(0, 3) == 0) begin
            in_if.TVALID = 1'b0;
            @(posedge ap_clk);
            #1;
         end
         drive_beat(d, k, l, tid, tuser, tdest);
      end
      in_if.TVALID = 1'b0;
      in_if.TLAST  = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      for (int c = 0; c < 2000 && exp_q.size() != 0; c++) @(negedge ap_clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: got %0d beats outstanding want 0", name, exp_q.size());
         exp_q.delete();
      end
      repeat (4) @(negedge ap_clk);
   endtask

   task automatic test_reset();
      ap_rst_n     = 1'b0;
      in_if.TVALID = 1'b0;
      in_if.TDATA  = '0;
      in_if.TKEEP  = '0;
      in_if.TLAST  = 1'b0;
      in_if.TID    = '0;
      in_if.TUSER  = '0;
      in_if.TDEST  = '0;
      exp_err      = 1'b0;
      repeat (3) @(posedge ap_clk);
      #1;
      checks++;
      if ({out_if.TVALID, out_if.TDATA, out_if.TLAST, out_if.TKEEP, out_if.TDEST, err_len} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b data=%h last=%b keep=%h dest=%h err=%b want all 0",
                  out_if.TVALID, out_if.TDATA, out_if.TLAST, out_if.TKEEP, out_if.TDEST, err_len);
      end
      checks++;
      if (in_if.TREADY !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_ready: got %b want 0", in_if.TREADY);
      end
      ap_rst_n = 1'b1;
      repeat (2) @(posedge ap_clk);
      #1;
   endtask

   task automatic test_single();
      int n0 = out_beats;
      send_pkt(16'h0012, 16'd4, 16'h0003, 4, 1'b0);
      wait_drain("single");
      checks++;
      if (out_beats - n0 != 5) begin
         errors++;
         $display("FAIL single_count: got %0d want 5", out_beats - n0);
      end
      checks++;
      if (err_len !== 1'b0) begin
         errors++;
         $display("FAIL single_err_len: got %b want 0", err_len);
      end
   endtask

   task automatic test_back_to_back();
      int n0 = out_beats;
      send_pkt(16'h0001, 16'd1, 16'h0005, 1, 1'b0);
      send_pkt(16'h0002, 16'd1, 16'h0006, 1, 1'b0);
      wait_drain("b2b");
      checks++;
      if (out_beats - n0 != 4) begin
         errors++;
         $display("FAIL b2b_count: got %0d want 4", out_beats - n0);
      end
   endtask

   task automatic test_random_ready();
      int n0 = out_beats;
      rand_rdy = 1'b1;
      send_pkt(16'h00A5, 16'd8, 16'h1234, 8, 1'b1);
      wait_drain("rand_ready");
      rand_rdy = 1'b0;
      repeat (2) @(negedge ap_clk);
      checks++;
      if (out_beats - n0 != 9) begin
         errors++;
         $display("FAIL rand_ready_count: got %0d want 9", out_beats - n0);
      end
   endtask

   task automatic test_mid_reset();
      int n0;
      exp_q.push_back(mk(hdr_of(16'h0033, 16'd6, 16'h0009), 8'hFF, 1'b0, 16'h0009));
      for (int b = 0; b < 2; b++) begin
         logic [63:0] d = {$urandom(), $urandom()};
         exp_q.push_back(mk(d, 8'hFF, 1'b0, 16'h0009));
         drive_beat(d, 8'hFF, 1'b0, 16'h0033, 16'd6, 16'h0009);
      end
      #2;
      ap_rst_n = 1'b0;
      #1;
      checks++;
      if (out_if.TVALID !== 1'b0 || out_if.TLAST !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_async: got valid=%b last=%b want 0 0", out_if.TVALID, out_if.TLAST);
      end
      exp_q.delete();
      exp_err      = 1'b0;
      in_if.TVALID = 1'b0;
      repeat (2) @(posedge ap_clk);
      #1;
      ap_rst_n = 1'b1;
      @(posedge ap_clk);
      #1;
      n0 = out_beats;
      send_pkt(16'h0044, 16'd3, 16'h000A, 3, 1'b0);
      wait_drain("post_reset");
      checks++;
      if (out_beats - n0 != 4) begin
         errors++;
         $display("FAIL post_reset_count: got %0d want 4", out_beats - n0);
      end
   endtask

   task automatic test_len_mismatch();
      int n0 = out_beats;
`ifdef AM_HEADER_LEN_CHECK_EN
      int want = 4;
`else
      int want = 6;
`endif
      send_pkt(16'h0055, 16'd3, 16'h0007, 5, 1'b0);
      wait_drain("len");
      checks++;
      if (out_beats - n0 != want) begin
         errors++;
         $display("FAIL len_count: got %0d want %0d", out_beats - n0, want);
      end
      checks++;
      if (err_len !== exp_err) begin
         errors++;
         $display("FAIL len_err: got %b want %b", err_len, exp_err);
      end
      send_pkt(16'h0056, 16'd2, 16'h0007, 2, 1'b0);
      wait_drain("len_sticky");
      checks++;
      if (err_len !== exp_err) begin
         errors++;
         $display("FAIL len_err_sticky: got %b want %b", err_len, exp_err);
      end
      send_pkt(16'h0057, 16'd0, 16'h0008, 1, 1'b0);
      wait_drain("tuser_zero");
      checks++;
      if (err_len !== exp_err) begin
         errors++;
         $display("FAIL tuser_zero_err: got %b want %b", err_len, exp_err);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_random_ready();
      test_mid_reset();
      test_len_mismatch();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/am_header_insert.md
Name: am_header_insert

Overview:
- Sits directly downstream of the GAScore ID/length tagging stage.
- Consumes AXIS packets whose TID carries the destination node ID and whose TUSER carries the packet beat count, both constant for the whole packet.
- Prepends one header beat carrying {TDEST, beat count, destination ID}, then forwards the payload unchanged, producing a self-describing packet for the network egress.
- Output is fully registered: one pipeline register, no combinational path from in_* to out_*.

Parameters:
- TDATA_WIDTH, 64, data width in bits; must be >= 64.
- TDEST_WIDTH, 16, TDEST width in bits; must be <= 16.
- TID_WIDTH, 16, input TID (destination ID) width in bits; must be <= 16.
- TUSER_WIDTH, 16, input TUSER (beat count) width in bits; must be <= 16.
- TKEEP_WIDTH, TDATA_WIDTH/8, TKEEP width in bits.

Ports:
- ap_clk, in, 1, clock.
- ap_rst_n, in, 1, reset; asynchronous, active-low.
- in_TDATA, in, TDATA_WIDTH, payload data.
- in_TVALID, in, 1, input valid.
- in_TREADY, out, 1, input ready.
- in_TDEST, in, TDEST_WIDTH, packet destination.
- in_TLAST, in, 1, end of packet.
- in_TKEEP, in, TKEEP_WIDTH, byte enables.
- in_TID, in, TID_WIDTH, destination node ID.
- in_TUSER, in, TUSER_WIDTH, packet length in beats.
- out_TDATA, out, TDATA_WIDTH, header or payload data.
- out_TVALID, out, 1, output valid.
- out_TREADY, in, 1, output ready.
- out_TDEST, out, TDEST_WIDTH, latched packet TDEST.
- out_TLAST, out, 1, end of packet.
- out_TKEEP, out, TKEEP_WIDTH, byte enables.
- err_len, out, 1, sticky length-mismatch flag.

Behaviour:
- Reset (ap_rst_n low, asynchronous):
  - out_TVALID=0, out_TDATA=0, out_TDEST=0, out_TLAST=0, out_TKEEP=0, err_len=0.
  - State S_HDR; beat_cnt=0.
- Definitions:
  - slot_free = ~out_TVALID | out_TREADY.
  - out_TVALID clears on out_TREADY when no new load occurs in the same cycle.
- State S_HDR:
  - in_TREADY=0.
  - If in_TVALID & slot_free: load the header beat into the output register, latch in_TDEST, in_TUSER and in_TID, set beat_cnt=0, go to S_PAY.
  - Header beat: out_TDATA[15:0]=in_TID (zero-extended); [31:16]=in_TUSER (zero-extended); [47:32]=in_TDEST (zero-extended); all upper bits 0.
  - Header beat sideband: out_TKEEP all ones, out_TLAST=0, out_TDEST=in_TDEST.
- State S_PAY:
  - in_TREADY=slot_free.
  - On each input handshake: the output register takes in_TDATA, in_TKEEP, in_TLAST; out_TDEST holds the latched value; beat_cnt increments (16-bit, saturating at 0xFFFF).
  - If in_TLAST on the handshake: go to S_HDR.
- Latency and throughput:
  - Header is valid the cycle after in_TVALID is first seen in S_HDR.
  - Each payload beat appears one cycle after its handshake.
  - An N-beat packet occupies N+1 output beats.
  - Back-to-back packets: one bubble-free header insertion per packet; sustained rate is N/(N+1).
- Backpressure: out_TREADY=0 holds the output register stable (AXIS compliant); in_TREADY drops in the same cycle.
- Boundary cases:
  - TUSER=0 is passed through unchecked in the header.
  - A single-beat packet yields a header beat plus one beat with TLAST=1.
  - in_TVALID deasserting mid-packet simply stalls; the state is kept.
- Reset mid-packet: the partial packet is discarded and the downstream stage sees no TLAST; recovery is the system's responsibility.

Optional Feature:
- Macro: AM_HEADER_LEN_CHECK_EN.
- Defined:
  - At the TLAST handshake in S_PAY, compare beat_cnt+1 with the latched TUSER.
  - On mismatch, err_len is set to 1 and holds until reset.
  - A payload beat that would exceed the latched TUSER with TLAST=0 is forwarded with out_TLAST forced to 1, and err_len is set.
  - The remaining beats of that packet are consumed and dropped (in_TREADY=1, nothing loaded) until in_TLAST.
- Undefined: err_len is tied to 0; no comparison, truncation or drop logic is built.

Test Plan:
- Single 4-beat packet, TID=0x0012, TUSER=4, TDEST=0x3, out_TREADY=1 -> 5 output beats; first has TDATA=0x0000_0003_0004_0012, TLAST=0; beat 5 has TLAST=1; err_len=0.
- Two back-to-back 1-beat packets (TID=1/TUSER=1, TID=2/TUSER=1) -> output sequence H1, D1(TLAST), H2, D2(TLAST); no beats lost or duplicated.
- Random out_TREADY (50%) on an 8-beat packet -> output stays stable while stalled; data order is identical to input; 9 beats total.
- Reset asserted after 2 payload beats of a 6-beat packet -> out_TVALID=0 immediately (asynchronous); the next packet starts with a correct header.
- With AM_HEADER_LEN_CHECK_EN defined, TUSER=3 and actual length 5 -> 4 output beats (header + 3, the third with TLAST=1), beats 4-5 dropped, err_len=1 and sticky.
- With AM_HEADER_LEN_CHECK_EN undefined, the same stimulus -> 6 output beats, err_len=0.
